// File: rtl/risc_v_mike_instr_mem_sync_if.sv
// Fetch and program-load bus of the synchronous instruction memory.
// The master is the fetch stage or bootloader. The slave is the memory.
interface risc_v_mike_instr_mem_sync_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_err;
  logic              init_done;

  modport master (
    output fetch_req, fetch_addr, prog_we, prog_addr, prog_data,
    input  fetch_ready, fetch_valid, fetch_data, fetch_err, prog_err, init_done
  );

  modport slave (
    input  fetch_req, fetch_addr, prog_we, prog_addr, prog_data,
    output fetch_ready, fetch_valid, fetch_data, fetch_err, prog_err, init_done
  );
endinterface

// File: rtl/risc_v_mike_instr_mem_sync.sv
// Writable instruction memory with a one-cycle synchronous fetch, a program-load port and a post-reset clear sweep.
// Define RISC_V_MIKE_IMEM_NOP_FILL_EN to make the sweep fill the array with the RV32I NOP instead of zero.
module risc_v_mike_instr_mem_sync #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input logic                          clk,
  input logic                          rst_n,
  risc_v_mike_instr_mem_sync_if.slave  imem
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

`ifdef RISC_V_MIKE_IMEM_NOP_FILL_EN
  localparam logic [DATA_W-1:0] FILL_WORD = DATA_W'(32'h0000_0013);
`else
  localparam logic [DATA_W-1:0] FILL_WORD = '0;
`endif

  // A byte address is usable only if it is word aligned and its word index lies inside the array.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] word_addr;
    word_addr = addr >> 2;
    return (addr[1:0] == 2'b00) && (word_addr < ADDR_W'(DEPTH));
  endfunction

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
  logic              fetch_err_q, fetch_err_d;
  logic              prog_err_q, prog_err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic             is_ready;
  logic             fetch_ok;
  logic             prog_ok;
  logic             fetch_accept;
  logic             prog_commit;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] prog_idx;

  assign is_ready     = (state_q == ST_READY);
  assign fetch_ok     = addr_ok(imem.fetch_addr);
  assign prog_ok      = addr_ok(imem.prog_addr);
  assign fetch_idx    = imem.fetch_addr[2 +: IDX_W];
  assign prog_idx     = imem.prog_addr[2 +: IDX_W];
  // A program write wins the cycle. Fetch and write therefore never touch the array together.
  assign fetch_accept = is_ready & imem.fetch_req & ~imem.prog_we;
  assign prog_commit  = is_ready & imem.prog_we & prog_ok;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    fetch_valid_d = fetch_accept;
    fetch_err_d   = fetch_accept & ~fetch_ok;
    fetch_data_d  = fetch_data_q;
    prog_err_d    = imem.prog_we & (~is_ready | ~prog_ok);

    if (fetch_accept) begin
      fetch_data_d = fetch_ok ? mem_q[fetch_idx] : '0;
    end

    if (!is_ready) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(DEPTH - 1)) begin
        state_d = ST_READY;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      fetch_err_q   <= 1'b0;
      prog_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
      fetch_err_q   <= fetch_err_d;
      prog_err_q    <= prog_err_d;
    end
  end

  // NOTE: the array has no reset, so it can map onto RAM. The INIT sweep clears it one word per cycle.
  always_ff @(posedge clk) begin
    if (!is_ready) begin
      mem_q[cnt_q] <= FILL_WORD;
    end else if (prog_commit) begin
      mem_q[prog_idx] <= imem.prog_data;
    end
  end

  assign imem.fetch_ready = is_ready & ~imem.prog_we;
  assign imem.fetch_valid = fetch_valid_q;
  assign imem.fetch_data  = fetch_data_q;
  assign imem.fetch_err   = fetch_err_q;
  assign imem.prog_err    = prog_err_q;
  assign imem.init_done   = is_ready;

endmodule

// File: tb/tb_risc_v_mike_instr_mem_sync.sv
// Self-checking bench for risc_v_mike_instr_mem_sync with DEPTH=16.
// It uses a directed vector table, hand sequences for init and reset, and random traffic checked against an array model.
module tb_risc_v_mike_instr_mem_sync;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

`ifdef RISC_V_MIKE_IMEM_NOP_FILL_EN
  localparam logic [31:0] FILL = 32'h0000_0013;
`else
  localparam logic [31:0] FILL = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  risc_v_mike_instr_mem_sync_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  risc_v_mike_instr_mem_sync #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .imem (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic        req;
    logic [31:0] faddr;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_err;
    logic        e_perr;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model_mem [DEPTH];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] paddr, input logic [31:0] pdata,
                       input logic req, input logic [31:0] faddr);
    bus.prog_we    = we;
    bus.prog_addr  = paddr;
    bus.prog_data  = pdata;
    bus.fetch_req  = req;
    bus.fetch_addr = faddr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check1 ({tag, "_ready"},     bus.fetch_ready, 1'b0);
    check1 ({tag, "_valid"},     bus.fetch_valid, 1'b0);
    check32({tag, "_data"},      bus.fetch_data,  32'h0);
    check1 ({tag, "_err"},       bus.fetch_err,   1'b0);
    check1 ({tag, "_perr"},      bus.prog_err,    1'b0);
    check1 ({tag, "_init_done"}, bus.init_done,   1'b0);
  endtask

  // Counts cycles from reset release until init_done. The count is bounded, so a stuck sweep cannot hang the bench.
  task automatic count_sweep(input int start, output int cycles);
    cycles = start;
    while (!bus.init_done && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  // Fetches one word and checks the result on the following cycle.
  task automatic fetch_expect(input string name, input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b0, 32'h0, 32'h0, 1'b1, addr);
    tick();
    check1 ({name, "_valid"}, bus.fetch_valid, 1'b1);
    check32({name, "_data"},  bus.fetch_data,  exp);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] paddr, input logic [31:0] pdata,
                              input logic req, input logic [31:0] faddr,
                              input logic e_ready, input logic e_valid, input logic [31:0] e_data,
                              input logic e_err, input logic e_perr);
    vec_t v;
    v.we = we;  v.paddr = paddr;  v.pdata = pdata;  v.req = req;  v.faddr = faddr;
    v.e_ready = e_ready;  v.e_valid = e_valid;  v.e_data = e_data;
    v.e_err = e_err;  v.e_perr = e_perr;
    return v;
  endfunction

  function automatic bit m_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a / 4) < 32'(DEPTH));
  endfunction

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = int'($urandom_range(0, 7));
    if (sel == 0) return $urandom();
    if (sel == 1) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
    return 32'($urandom_range(0, DEPTH - 1)) << 2;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [31:0] exp_last;

    // Reset values.
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Init sweep. The prog_we and fetch_req seen on the first INIT edge must be ignored.
    drive(1'b1, 32'h0, 32'hDEAD_BEEF, 1'b1, 32'h0);
    rst_n = 1'b1;
    tick();
    check1("init_prog_err",   bus.prog_err,    1'b1);
    check1("init_no_valid",   bus.fetch_valid, 1'b0);
    check1("init_done_early", bus.init_done,   1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    check1("init_prog_err_clear", bus.prog_err, 1'b0);
    count_sweep(2, cyc);
    check32("init_cycles", 32'(cyc), 32'(DEPTH));
    check1("init_fetch_ready", bus.fetch_ready, 1'b1);

    // Directed vectors. Each expected output is the value one cycle after the inputs are applied.
    vecs.push_back(mk(0, 32'h0,  32'h0,          1, 32'h0,        1, 1, FILL,         0, 0));
    vecs.push_back(mk(1, 32'h0,  32'h00f00093,   0, 32'h0,        0, 0, FILL,         0, 0));
    vecs.push_back(mk(1, 32'h4,  32'h00800113,   0, 32'h0,        0, 0, FILL,         0, 0));
    vecs.push_back(mk(1, 32'h8,  32'h002081b3,   0, 32'h0,        0, 0, FILL,         0, 0));
    vecs.push_back(mk(0, 32'h0,  32'h0,          1, 32'h0,        1, 1, 32'h00f00093, 0, 0));
    vecs.push_back(mk(0, 32'h0,  32'h0,          1, 32'h4,        1, 1, 32'h00800113, 0, 0));
    vecs.push_back(mk(0, 32'h0,  32'h0,          1, 32'h8,        1, 1, 32'h002081b3, 0, 0));
    vecs.push_back(mk(0, 32'h0,  32'h0,          0, 32'h0,        1, 0, 32'h002081b3, 0, 0));
    vecs.push_back(mk(0, 32'h0,  32'h0,          1, 32'h2,        1, 1, 32'h0,        1, 0));
    vecs.push_back(mk(0, 32'h0,  32'h0,          1, 32'h40,       1, 1, 32'h0,        1, 0));
    vecs.push_back(mk(1, 32'h40, 32'h12345678,   0, 32'h0,        0, 0, 32'h0,        0, 1));
    vecs.push_back(mk(0, 32'h0,  32'h0,          1, 32'h0,        1, 1, 32'h00f00093, 0, 0));
    vecs.push_back(mk(1, 32'hC,  32'hAABBCCDD,   1, 32'hC,        0, 0, 32'h00f00093, 0, 0));
    vecs.push_back(mk(0, 32'h0,  32'h0,          1, 32'hC,        1, 1, 32'hAABBCCDD, 0, 0));
    vecs.push_back(mk(0, 32'h0,  32'h0,          1, 32'h3C,       1, 1, FILL,         0, 0));
    vecs.push_back(mk(1, 32'h3,  32'h55555555,   0, 32'h0,        0, 0, FILL,         0, 1));
    vecs.push_back(mk(0, 32'h0,  32'h0,          1, 32'h0,        1, 1, 32'h00f00093, 0, 0));
    vecs.push_back(mk(0, 32'h0,  32'h0,          1, 32'hFFFFFFFC, 1, 1, 32'h0,        1, 0));
    vecs.push_back(mk(0, 32'h0,  32'h0,          1, 32'h3E,       1, 1, 32'h0,        1, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].paddr, vecs[i].pdata, vecs[i].req, vecs[i].faddr);
      #1;
      check1($sformatf("vec%0d_ready", i), bus.fetch_ready, vecs[i].e_ready);
      tick();
      check1 ($sformatf("vec%0d_valid", i), bus.fetch_valid, vecs[i].e_valid);
      check32($sformatf("vec%0d_data",  i), bus.fetch_data,  vecs[i].e_data);
      check1 ($sformatf("vec%0d_err",   i), bus.fetch_err,   vecs[i].e_err);
      check1 ($sformatf("vec%0d_perr",  i), bus.prog_err,    vecs[i].e_perr);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Assert reset while a fetch result is on the outputs.
    fetch_expect("pre_rst_fetch", 32'h0, 32'h00f00093);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_fetch");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) tick();
    check1("mid_sweep_not_done", bus.init_done, 1'b0);

    // Assert reset again in the middle of the sweep. The sweep must then restart from zero.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_sweep");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_sweep(0, cyc);
    check32("resweep_cycles", 32'(cyc), 32'(DEPTH));
    fetch_expect("post_rst_w0",  32'h0,  FILL);
    fetch_expect("post_rst_w2",  32'h8,  FILL);
    fetch_expect("post_rst_w3c", 32'h3C, FILL);

    // Random traffic checked against the word-array model.
    foreach (model_mem[i]) model_mem[i] = FILL;
    exp_last = FILL;
    for (int n = 0; n < 300; n++) begin
      int          op;
      logic        we, req;
      logic [31:0] paddr, pdata, faddr;
      logic        e_valid, e_err, e_perr;
      logic [31:0] e_data;

      op    = int'($urandom_range(0, 3));
      we    = op[0];
      req   = op[1];
      paddr = rand_addr();
      pdata = $urandom();
      faddr = rand_addr();

      e_valid = 1'b0;
      e_err   = 1'b0;
      e_perr  = 1'b0;
      if (we) begin
        if (m_ok(paddr)) model_mem[paddr / 4] = pdata;
        else             e_perr = 1'b1;
      end else if (req) begin
        e_valid = 1'b1;
        if (m_ok(faddr)) begin
          exp_last = model_mem[faddr / 4];
        end else begin
          exp_last = 32'h0;
          e_err    = 1'b1;
        end
      end
      e_data = exp_last;

      drive(we, paddr, pdata, req, faddr);
      #1;
      check1($sformatf("rnd%0d_ready", n), bus.fetch_ready, ~we);
      tick();
      check1 ($sformatf("rnd%0d_valid", n), bus.fetch_valid, e_valid);
      check32($sformatf("rnd%0d_data",  n), bus.fetch_data,  e_data);
      check1 ($sformatf("rnd%0d_err",   n), bus.fetch_err,   e_err);
      check1 ($sformatf("rnd%0d_perr",  n), bus.prog_err,    e_perr);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_v_mike_instr_mem_sync.md
Name: risc_v_mike_instr_mem_sync

Overview:
Parametrised, writable instruction memory with synchronous read. It replaces the hard-wired combinational instruction ROM feeding the fetch stage. A post-reset init sweep clears the array, and a program-load port lets the testbench or bootloader write instruction words. The fetch port uses a request/valid handshake with one-cycle latency and flags misaligned or out-of-range addresses.

Parameters:
DATA_W, 32, instruction word width in bits.
DEPTH, 1024, number of words; must be a power of 2 and at least 4.
ADDR_W, 32, byte-address width of the fetch and program ports (matches t_pc_addr).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-low (asserted at 0).
fetch_req  input  1  fetch request; sampled only when fetch_ready=1.
fetch_addr  input  ADDR_W  byte address of the instruction.
fetch_ready  output  1  memory can accept a fetch this cycle.
fetch_valid  output  1  fetch_data/fetch_err valid for exactly 1 cycle.
fetch_data  output  DATA_W  instruction word read.
fetch_err  output  1  misaligned or out-of-range fetch.
prog_we  input  1  program write strobe.
prog_addr  input  ADDR_W  byte address for the program write.
prog_data  input  DATA_W  word to write.
prog_err  output  1  1-cycle pulse when a rejected program write is dropped.
init_done  output  1  init sweep complete.

Behaviour:
- Index: idx = addr[2 +: log2(DEPTH)].
- Misaligned: addr[1:0] != 0.
- Out-of-range: (addr >> 2) >= DEPTH.
- Reset values, while rst=0 asynchronously: state=INIT, sweep counter=0, fetch_ready=0, fetch_valid=0, fetch_data=0, fetch_err=0, prog_err=0, init_done=0. Array contents are not reset directly; the sweep clears them.
- FSM states: INIT and READY.
- INIT:
  - Writes the fill word (0) to word[cnt] each cycle; cnt increments.
  - When cnt = DEPTH-1 is written, the next state is READY and init_done goes to 1. The sweep takes exactly DEPTH cycles after reset deassertion.
  - fetch_req and prog_we are ignored. prog_err pulses 1 for each prog_we seen in INIT.
- READY:
  - fetch_ready = ~prog_we. A program write has priority and blocks fetch in the same cycle.
  - Accepted fetch (fetch_req & fetch_ready), valid address: the next cycle gives fetch_valid=1, fetch_data=word[idx], fetch_err=0.
  - Accepted fetch, invalid address: the next cycle gives fetch_valid=1, fetch_data=0, fetch_err=1.
  - No accepted fetch: the next cycle gives fetch_valid=0. fetch_data holds its last value; fetch_err=0.
  - Back-to-back fetches give 1 result per cycle.
  - prog_we with a valid address writes word[idx]=prog_data at the edge.
  - prog_we with an invalid address drops the write; the next cycle gives prog_err=1.
  - Write-then-read to the same word in a later cycle returns the new data. A same-cycle conflict cannot happen because fetch is blocked.
- rst asserted mid-sweep or mid-fetch: all outputs return to reset values immediately. Any pending fetch_valid is lost and the sweep restarts from 0 after deassertion.
- READY is terminal until reset.

Optional Feature:
RISC_V_MIKE_IMEM_NOP_FILL_EN.
- Defined: the init sweep writes the RV32I NOP 32'h00000013 instead of 0, so unprogrammed words execute as NOPs.
- Undefined: the fill word is 32'h00000000.
- Timing and all other behaviour are identical in both cases.

Test Plan:
- Init sweep, DEPTH=16: release rst and count cycles -> init_done=1 and fetch_ready=1 after exactly 16 cycles; prog_we during INIT -> prog_err pulse, no write.
- Program then fetch: write 32'h00f00093@0x0, 32'h00800113@0x4, 32'h002081b3@0x8; fetch 0x0, 0x4, 0x8 back-to-back -> fetch_valid on 3 consecutive cycles with those words, each 1 cycle after its request.
- Errors: fetch 0x2 -> fetch_valid=1, fetch_err=1, fetch_data=0; fetch 0x40 with DEPTH=16 -> fetch_err=1; prog_we@0x40 -> prog_err=1, and word 0 is unchanged.
- Priority: prog_we=1 and fetch_req=1 in the same cycle -> fetch_ready=0, no fetch_valid next cycle, write completes; the retried fetch returns the new data.
- Reset mid-operation: assert rst while fetch_valid is pending and mid-sweep -> outputs are 0 immediately; after release the full DEPTH-cycle sweep repeats and previously written words read back as the fill word.
- Fill word: unprogrammed word 0x3C reads 32'h00000000 without RISC_V_MIKE_IMEM_NOP_FILL_EN and 32'h00000013 with it.
